stream_demux_1to4: RTL and testbench
====================================

// Module: stream_demux_1to4
// PURPOSE
//  Registered 1-to-4 demultiplexer for a packetised valid/ready stream; inverse of the team's 4:1 mux cells.
//  Routes each packet (in_sel latched on its first beat) to one of four output ports through one output register stage.
//  Keeps a per-port packet count for debug. Sits between a single producer and four downstream consumers.
// PARAMETERS
//  DW  8  data width of in_data / out_data
//  CW  8  width of each per-port packet counter (wraps)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   DW     input beat payload
//  in_last    in   1      final beat of packet
//  in_sel     in   2      destination port; sampled only on a packet's first beat
//  out_valid  out  4      one-hot; bit k = beat pending on port k
//  out_ready  in   4      per-port consumer ready
//  out_data   out  DW     shared payload bus, qualified by out_valid[k]
//  out_last   out  1      shared last flag, qualified by out_valid[k]
//  busy       out  1      1 while a packet is mid-transfer (state ROUTE)
//  pkt_cnt    out  4*CW   {cnt3,cnt2,cnt1,cnt0}; packets completed per port
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, dest=0, stage empty, out_valid=0, out_data=0, out_last=0, busy=0, all pkt_cnt=0.
//   Reset mid-packet drops the in-flight beat and the rest of the packet; the next accepted beat is treated as a packet head.
//  FSM states IDLE, ROUTE:
//   IDLE: accepted beat latches dest<=in_sel; -> ROUTE if in_last=0, stays IDLE if in_last=1 (1-beat packet).
//   ROUTE: in_sel ignored; dest held; accepted beat with in_last=1 -> IDLE.
//  Output stage: one register {data,last}, plus stage_valid. out_valid = stage_valid ? (4'b1 << dest_of_stage) : 0.
//   dest_of_stage is registered with the beat, so it stays correct when a new packet head is accepted in the same cycle.
//  in_ready = ~stage_valid | out_ready[dest_of_stage] (full throughput; out_ready of unselected ports is ignored).
//  Latency: accepted beat appears on out_* the following cycle. Sustained 1 beat/clk when the consumer is ready.
//  Handshake rules:
//   - in_ready is combinational on out_ready; no combinational path from in_valid to in_ready.
//   - While out_valid[k]=1 and out_ready[k]=0, out_data, out_last and out_valid hold stable.
//   - in_ready=0 whenever the stage is full and its consumer stalls, even if the next packet targets another port (in-order, no bypass).
//  Counters: pkt_cnt[k] += 1 when out_valid[k] & out_ready[k] & out_last; wraps 2^CW-1 -> 0 silently.
//  Simultaneous events:
//   - A stage drain and a new accept in the same cycle keep the stage full with the new beat.
//   - A counter increment and a reset in the same cycle: reset wins.
//  busy = (state==ROUTE). A 1-beat packet never raises busy.
// STRUCTURE
//  Package stream_demux_pkg:
//   - localparam NPORT=4, SELW=2
//   - typedef enum {IDLE, ROUTE} demux_state_t
//  Sub-module pkt_counter #(CW) (clk, rst, inc, cnt): one instance per port, generated with NPORT.
//  Top module holds the FSM, the output stage and the ready logic.
// TESTING
//  1. Reset: after rst for 2 clks -> out_valid=0000, busy=0, pkt_cnt=0, in_ready=1.
//  2. 3-beat packet, in_sel=2, data A1,A2,A3, out_ready=1111 -> out_valid=0100 on 3 consecutive cycles, 1 cycle after each accept;
//     in_sel changed to 0 on beats 2-3 is ignored; pkt_cnt[2]=1.
//  3. Back-to-back 1-beat packets to ports 0,1,2,3 on consecutive cycles -> out_valid 0001,0010,0100,1000;
//     busy stays 0; every count=1.
//  4. Stall: port 1 beat pending, out_ready[1]=0 for 5 clks (out_ready[0]=1) -> in_ready=0, out_data stable;
//     release -> beat drains, next beat accepted the same cycle.
//  5. rst asserted after beat 2 of a 4-beat packet to port 3 -> out_valid=0 next clk; the following beat with in_sel=1 routes to port 1.
//  6. CW=2: send 5 packets to port 0 -> pkt_cnt[0] sequence 1,2,3,0,1.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants, FSM state type and port-decode helper for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

    localparam int NPORT = 4;
    localparam int SELW  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } demux_state_t;

    function automatic logic [NPORT-1:0] port_onehot(input logic [SELW-1:0] sel);
        logic [NPORT-1:0] v;
        v = {{(NPORT-1){1'b0}}, 1'b1} << sel;
        return v;
    endfunction

endpackage

// File: rtl/stream_demux_1to4_pkt_counter.sv
// Per-port completed-packet counter; wraps silently at 2^CW-1.
module pkt_counter
    import stream_demux_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    // Count register: reset has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {CW{1'b0}};
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 packet demultiplexer: destination latched on each packet head,
// one output register stage shared by all four ports, per-port packet counters.
module stream_demux_1to4
    import stream_demux_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    input  logic [SELW-1:0]     in_sel,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                busy,
    output logic [NPORT*CW-1:0] pkt_cnt
);

    demux_state_t    state_r;
    demux_state_t    state_next_s;
    logic [SELW-1:0] dest_r;
    logic [SELW-1:0] beat_dest_s;
    logic            stage_valid_r;
    logic [SELW-1:0] stage_dest_r;
    logic [DW-1:0]   stage_data_r;
    logic            stage_last_r;
    logic            accept_s;
    logic            drain_s;
    logic [NPORT-1:0] cnt_inc_s;

    // The stage carries its own destination, so a new head can be accepted while the old beat drains.
    assign in_ready  = ~stage_valid_r | out_ready[stage_dest_r];
    assign accept_s  = in_valid & in_ready;
    assign drain_s   = stage_valid_r & out_ready[stage_dest_r];
    assign out_valid = stage_valid_r ? port_onehot(stage_dest_r) : {NPORT{1'b0}};
    assign out_data  = stage_data_r;
    assign out_last  = stage_last_r;
    assign busy      = (state_r == ROUTE);
    assign cnt_inc_s = out_valid & out_ready & {NPORT{stage_last_r}};

    // Destination of the beat currently on the input: in_sel on a head, held dest otherwise.
    always_comb begin
        beat_dest_s = dest_r;
        if (state_r == IDLE) begin
            beat_dest_s = in_sel;
        end else begin
            beat_dest_s = dest_r;
        end
    end

    // Packet framing next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !in_last) begin
                    state_next_s = ROUTE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROUTE: begin
                if (accept_s && in_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ROUTE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state and per-packet destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            dest_r  <= {SELW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                dest_r <= beat_dest_s;
            end else begin
                dest_r <= dest_r;
            end
        end
    end

    // Output stage: load on accept, empty on drain without refill, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_r <= 1'b0;
            stage_dest_r  <= {SELW{1'b0}};
            stage_data_r  <= {DW{1'b0}};
            stage_last_r  <= 1'b0;
        end else if (accept_s) begin
            stage_valid_r <= 1'b1;
            stage_dest_r  <= beat_dest_s;
            stage_data_r  <= in_data;
            stage_last_r  <= in_last;
        end else if (drain_s) begin
            stage_valid_r <= 1'b0;
        end else begin
            stage_valid_r <= stage_valid_r;
        end
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_cnt
        pkt_counter #(
            .CW(CW)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .inc(cnt_inc_s[k]),
            .cnt(pkt_cnt[k*CW +: CW])
        );
    end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4 with a scoreboard queue of expected output beats.
module tb_stream_demux_1to4;

    localparam int DW = 8;
    localparam int CW = 2;

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic [4*CW-1:0] pkt_cnt;

    int n_pass  = 0;
    int n_total = 0;

    beat_t          sb[$];
    logic [CW-1:0]  m_cnt[4];
    logic           m_inpkt;
    logic [1:0]     m_dest;

    always #5 clk = ~clk;

    stream_demux_1to4 #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_sel(in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        sb.delete();
        for (int p = 0; p < 4; p++) m_cnt[p] = '0;
        m_inpkt = 1'b0;
        m_dest  = 2'd0;
    endtask

    // Called just after a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        logic [3:0] exp_v;
        logic       exp_rdy;
        logic       acc;
        logic       drn;
        logic [1:0] d;
        beat_t      b;
        #1;
        exp_v   = (sb.size() != 0) ? (4'b0001 << sb[0].port) : 4'b0000;
        exp_rdy = (sb.size() == 0) || out_ready[sb[0].port];
        chk("out_valid", {28'd0, out_valid}, {28'd0, exp_v});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("busy", {31'd0, busy}, {31'd0, m_inpkt});
        chk("pkt_cnt", {24'd0, pkt_cnt}, {24'd0, m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
        if (sb.size() != 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, sb[0].data});
            chk("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
        end
        acc = in_valid & exp_rdy;
        drn = (sb.size() != 0) && out_ready[sb[0].port];
        if (drn) begin
            if (sb[0].last) m_cnt[sb[0].port] = m_cnt[sb[0].port] + 2'd1;
            void'(sb.pop_front());
        end
        if (acc) begin
            d = m_inpkt ? m_dest : in_sel;
            b.port = d;
            b.data = in_data;
            b.last = in_last;
            sb.push_back(b);
            m_dest  = d;
            m_inpkt = ~in_last;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic beat(input logic [1:0] sel, input logic [DW-1:0] data, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        logic [1:0] seq_v[5];
        seq_v[0] = 2'd1; seq_v[1] = 2'd2; seq_v[2] = 2'd3; seq_v[3] = 2'd0; seq_v[4] = 2'd1;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = 2'd0;
        out_ready = 4'b1111;
        model_clear();

        // 1. reset state
        do_reset(2);
        idle(1);

        // 2. 3-beat packet to port 2, in_sel changes mid-packet are ignored
        beat(2'd2, 8'hA1, 1'b0);
        beat(2'd0, 8'hA2, 1'b0);
        beat(2'd0, 8'hA3, 1'b1);
        idle(2);
        chk("t2_cnt2", {30'd0, pkt_cnt[2*CW +: CW]}, 32'd1);

        // 3. back-to-back 1-beat packets to every port
        do_reset(1);
        for (int p = 0; p < 4; p++) beat(2'(p), 8'hB0 + 8'(p), 1'b1);
        idle(2);
        for (int p = 0; p < 4; p++) chk("t3_cnt", {30'd0, pkt_cnt[p*CW +: CW]}, 32'd1);

        // 4. port 1 stalls while port 0 is ready; the next head must wait in order
        do_reset(1);
        out_ready = 4'b1101;
        beat(2'd1, 8'hC1, 1'b1);
        for (int i = 0; i < 5; i++) beat(2'd0, 8'hC2, 1'b1);
        out_ready = 4'b1111;
        beat(2'd0, 8'hC2, 1'b1);
        idle(2);

        // 5. reset in the middle of a 4-beat packet to port 3
        do_reset(1);
        beat(2'd3, 8'hD1, 1'b0);
        beat(2'd3, 8'hD2, 1'b0);
        do_reset(1);
        idle(1);
        beat(2'd1, 8'hD3, 1'b1);
        idle(2);

        // 6. counter wrap with CW=2
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            beat(2'd0, 8'hE0 + 8'(i), 1'b1);
            idle(1);
            chk("t6_wrap", {30'd0, pkt_cnt[1:0]}, {30'd0, seq_v[i]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
